// File: rtl/mat_operand_loader_pkg.sv
// Shared matrix package: loader FSM state encoding, default operand geometry
// and the index-width helper used by the multiply datapath and its loader.
package mat_operand_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_X = 2'd2,
    FLUSH  = 2'd3
  } ld_state_t;

  localparam int W_LAST_DEF = 35;
  localparam int X_LAST_DEF = 5;
  localparam int DATA_W_DEF = 8;

  // Width of an index that must reach `last`; never narrower than one bit.
  function automatic int idx_w(input int last);
    return (last < 1) ? 1 : $clog2(last + 1);
  endfunction

endpackage

// File: rtl/mat_operand_loader.sv
// Streams one frame of operands into the consumer's weight bank (A+1 entries)
// followed by its vector bank (B+1 entries), checking s_last framing.
//
// state  | meaning
// IDLE   | waiting for start; s_ready low
// LOAD_W | accepting weight operands, wc = next weight address
// LOAD_X | accepting vector operands, xc = next vector address
// FLUSH  | final vector strobe is out; report done or err, return to IDLE
module mat_operand_loader
  import mat_operand_loader_pkg::*;
#(
  parameter int A      = W_LAST_DEF,
  parameter int B      = X_LAST_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  w_we,
  output logic [idx_w(A)-1:0]   w_addr,
  output logic [DATA_W-1:0]     w_data,
  output logic                  x_we,
  output logic [idx_w(B)-1:0]   x_addr,
  output logic [DATA_W-1:0]     x_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WA = idx_w(A);
  localparam int XA = idx_w(B);
  localparam logic [WA-1:0] WC_LAST = WA'(A);
  localparam logic [XA-1:0] XC_LAST = XA'(B);

  ld_state_t     state;
  logic [WA-1:0] wc;
  logic [XA-1:0] xc;
  logic          last_ok;
  logic          xfer;

  // Handshake and status decode straight from the state register.
  assign s_ready = (state == LOAD_W) || (state == LOAD_X);
  assign busy    = (state != IDLE);
  assign xfer    = s_valid && s_ready;

  // Frame sequencing with registered write strobes and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wc      <= '0;
      xc      <= '0;
      last_ok <= 1'b0;
      w_we    <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
      x_we    <= 1'b0;
      x_addr  <= '0;
      x_data  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      w_we <= 1'b0;
      x_we <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // A start landing on the done/err cycle belongs to the old frame.
          if (start && !done && !err) begin
            state <= LOAD_W;
            wc    <= '0;
            xc    <= '0;
          end
        end
        LOAD_W: begin
          if (xfer) begin
            w_we   <= 1'b1;
            w_addr <= wc;
            w_data <= s_data;
            if (wc != WC_LAST) wc <= wc + WA'(1);
            if (s_last) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (wc == WC_LAST) begin
              state <= LOAD_X;
            end
          end
        end
        LOAD_X: begin
          if (xfer) begin
            x_we   <= 1'b1;
            x_addr <= xc;
            x_data <= s_data;
            if (xc != XC_LAST) xc <= xc + XA'(1);
            if (xc == XC_LAST) begin
              last_ok <= s_last;
              state   <= FLUSH;
            end else if (s_last) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          done  <= last_ok;
          err   <= !last_ok;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Randomised frame bench for mat_operand_loader against a frame-level model.
module tb_mat_operand_loader;

  localparam int NW = 36;
  localparam int NX = 6;
  localparam int NT = NW + NX;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       w_we;
  logic [5:0] w_addr;
  logic [7:0] w_data;
  logic       x_we;
  logic [2:0] x_addr;
  logic [7:0] x_data;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int obs_wa[$];
  int obs_wd[$];
  int obs_xa[$];
  int obs_xd[$];
  int n_done = 0;
  int n_err = 0;
  int pulse_cyc = 0;
  int last_strobe_cyc = 0;
  bit prev_xfer = 1'b0;

  mat_operand_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observe bank writes and pulses mid-cycle; strobes must follow transfers 1:1.
  always @(negedge clk) begin
    if (rst) begin
      prev_xfer = 1'b0;
    end else begin
      check("strobe_follows_xfer", {31'b0, w_we | x_we}, {31'b0, prev_xfer});
      check("done_err_exclusive", {31'b0, done & err}, 32'd0);
      if (w_we) begin
        obs_wa.push_back(int'(w_addr));
        obs_wd.push_back(int'(w_data));
        last_strobe_cyc = cyc;
      end
      if (x_we) begin
        obs_xa.push_back(int'(x_addr));
        obs_xd.push_back(int'(x_data));
        last_strobe_cyc = cyc;
      end
      if (done) begin n_done++; pulse_cyc = cyc; end
      if (err)  begin n_err++;  pulse_cyc = cyc; end
      prev_xfer = s_valid && s_ready;
    end
  end

  task automatic clear_obs();
    obs_wa.delete(); obs_wd.delete(); obs_xa.delete(); obs_xd.delete();
    n_done = 0; n_err = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
    check({tag, "_we"},      {30'b0, w_we, x_we}, 32'd0);
    check({tag, "_addr"},    {23'b0, w_addr, x_addr}, 32'd0);
    check({tag, "_data"},    {16'b0, w_data, x_data}, 32'd0);
    check({tag, "_status"},  {29'b0, busy, done, err}, 32'd0);
  endtask

  // last_pos: 1-based index of the byte carrying s_last (0 = never).
  // stall: 0 none, 1 every other cycle, 2 random. start_mid: byte index at which
  // start is re-pulsed (0 = never). start_end: pulse start on the done/err cycle.
  task automatic run_frame(input string tag, input int last_pos, input int stall,
                           input bit seq_data, input int start_mid, input bit start_end);
    logic [7:0] data [NT];
    int k_end, i, guard, exp_w, exp_x;
    bit v, xfer, seen;
    for (int j = 0; j < NT; j++) data[j] = seq_data ? 8'(j + 1) : 8'($urandom);
    k_end = (last_pos >= 1 && last_pos <= NT) ? last_pos : NT;
    exp_w = (k_end < NW) ? k_end : NW;
    exp_x = k_end - exp_w;
    clear_obs();

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0; guard = 0;
    while (i < NT && guard < 400) begin
      case (stall)
        0: v = 1'b1;
        1: v = (guard % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = v ? data[i] : 8'($urandom);
      s_last  = v && (i + 1 == last_pos);
      start   = v && (start_mid > 0) && (i + 1 == start_mid);
      xfer    = v && s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (xfer) begin
        i++;
        if (s_last) break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check({tag, "_xfers"}, i, k_end);

    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (done || err) begin
        seen = 1'b1;
        if (start_end) start = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_pulse_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_idle_at_pulse"}, {30'b0, busy, s_ready}, 32'd0);
      @(posedge clk); #1 start = 1'b0;
      check({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;

    check({tag, "_w_count"}, obs_wa.size(), exp_w);
    check({tag, "_x_count"}, obs_xa.size(), exp_x);
    for (int j = 0; j < obs_wa.size() && j < exp_w; j++) begin
      check({tag, "_w_addr"}, obs_wa[j], j);
      check({tag, "_w_data"}, obs_wd[j], int'(data[j]));
    end
    for (int j = 0; j < obs_xa.size() && j < exp_x; j++) begin
      check({tag, "_x_addr"}, obs_xa[j], j);
      check({tag, "_x_data"}, obs_xd[j], int'(data[NW + j]));
    end
    check({tag, "_done_count"}, n_done, (last_pos == NT) ? 1 : 0);
    check({tag, "_err_count"},  n_err,  (last_pos == NT) ? 0 : 1);
    if (n_done + n_err == 1)
      check({tag, "_pulse_delay"}, pulse_cyc - last_strobe_cyc, (k_end < NT) ? 0 : 1);
  endtask

  initial begin
    int lp, st;
    #3 reset_checks("por");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    reset_checks("idle");

    run_frame("clean",    NT, 0, 1'b1, 0, 1'b0);
    run_frame("stalled",  NT, 1, 1'b1, 0, 1'b0);
    run_frame("early",    10, 0, 1'b1, 0, 1'b0);
    run_frame("missing",  0,  0, 1'b1, 0, 1'b0);
    run_frame("start_in", NT, 0, 1'b1, 5, 1'b1);
    run_frame("last_w36", NW, 2, 1'b0, 0, 1'b1);
    run_frame("last_x41", NT - 1, 2, 1'b0, 0, 1'b0);

    // Reset mid-frame after 20 transfers.
    clear_obs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      s_data = 8'(j + 1);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    s_valid = 1'b0;
    #1 reset_checks("mid_rst");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_pulse", n_done + n_err, 0);
    reset_checks("after_rst");
    run_frame("post_rst", NT, 0, 1'b1, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 2))
        0: lp = NT;
        1: lp = 0;
        default: lp = $urandom_range(1, NT - 1);
      endcase
      st = $urandom_range(0, 2);
      run_frame("rand", lp, st, 1'b0, (r % 2 == 0) ? $urandom_range(1, 40) : 0, 1'(r % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
